// File: rtl/dm_hart_handshake.sv
// Hart-side debug-memory responder: decodes park-loop handshake stores, serves per-hart
// go/resume flag bytes and sequences abstract commands. Optional watchdog: DM_HART_TIMEOUT_EN.
module dm_hart_handshake #(
  parameter int AXI_DATA_W     = 32,
  parameter int NHART          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [11:0]           mem_addr,
  input  logic [AXI_DATA_W-1:0] mem_wdata,
  output logic                  mem_rsp,
  output logic [AXI_DATA_W-1:0] mem_rdata,
  input  logic [3:0]            hartsel,
  input  logic                  resumereq,
  input  logic                  cmd_start,
  output logic                  cmd_busy,
  output logic                  cmd_done,
  output logic                  cmd_exception,
  output logic                  cmd_err_halt,
  output logic [NHART-1:0]      halted,
  output logic [NHART-1:0]      resumeack
);

  if (AXI_DATA_W != 32 && AXI_DATA_W != 64) begin : g_bad_width
    $error("dm_hart_handshake: AXI_DATA_W must be 32 or 64");
  end
  if (NHART < 1 || NHART > 16) begin : g_bad_nhart
    $error("dm_hart_handshake: NHART must be 1..16");
  end

  localparam int LB    = (AXI_DATA_W == 64) ? 3 : 2;
  localparam int BYTES = AXI_DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_GO, S_EXEC} state_e;

  state_e                  state_q;
  logic [NHART-1:0]        halted_q, resumeack_q, go_q, resume_q;
  logic [3:0]              tgt_q;
  logic                    busy_q, done_q, exc_q, errh_q, rsp_q;
  logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;
`ifdef DM_HART_TIMEOUT_EN
  logic [15:0]             cnt_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // On a 64-bit bus the hartid sits in whichever 32-bit word the address names.
  logic                  word_hi;
  logic [AXI_DATA_W-1:0] wsh;
  logic [3:0]            wr_hart;
  logic                  unused_wdata;
  assign word_hi      = (AXI_DATA_W == 64) && mem_addr[2];
  assign wsh          = mem_wdata >> {word_hi, 5'b0};
  assign wr_hart      = wsh[3:0];
  assign unused_wdata = ^wsh[AXI_DATA_W-1:4];

  logic wr, hart_ok, wr_halted, wr_going, wr_resuming, wr_exc, tgt_hit;
  assign wr          = mem_req && mem_we;
  assign hart_ok     = int'(wr_hart) < NHART;
  assign wr_halted   = wr && hart_ok && (mem_addr == 12'h100);
  assign wr_going    = wr && hart_ok && (mem_addr == 12'h104);
  assign wr_resuming = wr && hart_ok && (mem_addr == 12'h108);
  assign wr_exc      = wr && hart_ok && (mem_addr == 12'h10C);
  assign tgt_hit     = (wr_hart == tgt_q);

  logic [15:0] halted_pad, go_pad, res_pad;
  logic        sel_ok, sel_halted, resume_ok;
  assign halted_pad = 16'(halted_q);
  assign go_pad     = 16'(go_q);
  assign res_pad    = 16'(resume_q);
  assign sel_ok     = int'(hartsel) < NHART;
  assign sel_halted = sel_ok && halted_pad[hartsel];
  // Resume sees the halted state after this cycle's store has been applied.
  assign resume_ok  = sel_ok &&
                      ((halted_pad[hartsel] && !(wr_resuming && wr_hart == hartsel)) ||
                       (wr_halted && wr_hart == hartsel));

  logic        rd_en;
  logic [11:0] rd_off;
  assign rd_en  = mem_req && !mem_we && (mem_addr >= 12'h400) &&
                  (int'(mem_addr) < 'h400 + NHART);
  assign rd_off = {mem_addr[11:LB], {LB{1'b0}}} - 12'h400;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    logic [11:0] idx;
    assign idx = rd_off + 12'(g);
    assign rdata_d[8*g +: 8] = (rd_en && int'(idx) < NHART) ?
                               {6'b0, res_pad[idx[3:0]], go_pad[idx[3:0]]} : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      halted_q    <= '0;
      resumeack_q <= '0;
      go_q        <= '0;
      resume_q    <= '0;
      tgt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
      errh_q      <= 1'b0;
      rsp_q       <= 1'b0;
      rdata_q     <= '0;
`ifdef DM_HART_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      rsp_q   <= mem_req;
      rdata_q <= rdata_d;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      errh_q  <= 1'b0;

      for (int k = 0; k < NHART; k++) begin
        if (wr_hart == 4'(k)) begin
          if (wr_halted) begin
            halted_q[k] <= 1'b1;
            resume_q[k] <= 1'b0;
          end
          if (wr_going) go_q[k] <= 1'b0;
          if (wr_resuming) begin
            halted_q[k]    <= 1'b0;
            resumeack_q[k] <= 1'b1;
            resume_q[k]    <= 1'b0;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (!sel_halted) begin
              errh_q <= 1'b1;
            end else begin
              tgt_q   <= hartsel;
              state_q <= S_GO;
              busy_q  <= 1'b1;
              for (int k = 0; k < NHART; k++)
                if (hartsel == 4'(k)) go_q[k] <= 1'b1;
`ifdef DM_HART_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end
          end else if (resumereq && resume_ok) begin
            for (int k = 0; k < NHART; k++)
              if (hartsel == 4'(k)) begin
                resume_q[k]    <= 1'b1;
                resumeack_q[k] <= 1'b0;
              end
          end
        end
        default: begin
          if (state_q == S_EXEC && tgt_hit && wr_exc) begin
            exc_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (state_q == S_EXEC && tgt_hit && wr_halted) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`ifdef DM_HART_TIMEOUT_EN
          end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            for (int k = 0; k < NHART; k++)
              if (tgt_q == 4'(k)) go_q[k] <= 1'b0;
            exc_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else begin
            if (state_q == S_GO && tgt_hit && wr_going) state_q <= S_EXEC;
`ifdef DM_HART_TIMEOUT_EN
            cnt_q <= cnt_q + 16'd1;
`endif
          end
        end
      endcase
    end
  end

  assign mem_rsp       = rsp_q;
  assign mem_rdata     = rdata_q;
  assign cmd_busy      = busy_q;
  assign cmd_done      = done_q;
  assign cmd_exception = exc_q;
  assign cmd_err_halt  = errh_q;
  assign halted        = halted_q;
  assign resumeack     = resumeack_q;

endmodule

// File: tb/tb_dm_hart_handshake.sv
// Bench for dm_hart_handshake: directed handshake scenarios plus a randomized run
// checked against a flag/command-level reference model.
module tb_dm_hart_handshake;
  localparam int NH = 4;
  localparam int TO = 8;

  logic          clk = 1'b0, rst = 1'b1;
  logic          mem_req = 1'b0, mem_we = 1'b0;
  logic [11:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          mem_rsp;
  logic [31:0]   mem_rdata;
  logic [3:0]    hartsel = '0;
  logic          resumereq = 1'b0, cmd_start = 1'b0;
  logic          cmd_busy, cmd_done, cmd_exception, cmd_err_halt;
  logic [NH-1:0] halted, resumeack;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  dm_hart_handshake #(.AXI_DATA_W(32), .NHART(NH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp(mem_rsp), .mem_rdata(mem_rdata),
    .hartsel(hartsel), .resumereq(resumereq), .cmd_start(cmd_start),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_exception(cmd_exception),
    .cmd_err_halt(cmd_err_halt), .halted(halted), .resumeack(resumeack)
  );

  // Reference model: flag bits per hart plus "command outstanding / hart has left the park loop".
  bit [NH-1:0] m_halted, m_ack, m_go, m_res;
  bit          m_busy, m_went;
  int          m_tgt;
`ifdef DM_HART_TIMEOUT_EN
  int          m_age;
`endif
  bit          e_rsp, e_done, e_exc, e_err;
  logic [31:0] e_rdata;

  function automatic void model_reset();
    m_halted = '0; m_ack = '0; m_go = '0; m_res = '0;
    m_busy = 0; m_went = 0; m_tgt = 0;
  endfunction

  function automatic void model_step(bit req, bit we, logic [11:0] addr, logic [31:0] wd,
                                     bit st, bit rr, int sel);
    int h;
    bit was_busy, fin, pre_sel_halted;
    e_rsp = req; e_rdata = '0; e_done = 0; e_exc = 0; e_err = 0;
    was_busy = m_busy; fin = 0;
    pre_sel_halted = (sel < NH) && m_halted[sel];
    if (req && !we && addr >= 12'h400 && int'(addr) < 'h400 + NH)
      for (int i = 0; i < 4; i++) begin
        h = int'(addr & 12'hFFC) - 'h400 + i;
        if (h < NH) e_rdata[8*i +: 8] = {6'b0, m_res[h], m_go[h]};
      end
    if (req && we && int'(wd[3:0]) < NH) begin
      h = int'(wd[3:0]);
      case (addr)
        12'h100: begin
          m_halted[h] = 1; m_res[h] = 0;
          if (was_busy && m_went && h == m_tgt) begin e_done = 1; fin = 1; end
        end
        12'h104: begin
          m_go[h] = 0;
          if (was_busy && h == m_tgt) m_went = 1;
        end
        12'h108: begin m_halted[h] = 0; m_ack[h] = 1; m_res[h] = 0; end
        12'h10C: if (was_busy && m_went && h == m_tgt) begin e_exc = 1; fin = 1; end
        default: ;
      endcase
    end
    if (fin) m_busy = 0;
`ifdef DM_HART_TIMEOUT_EN
    else if (was_busy) begin
      m_age++;
      if (m_age == TO) begin m_go[m_tgt] = 0; e_exc = 1; m_busy = 0; end
    end
`endif
    if (!was_busy && st) begin
      if (pre_sel_halted) begin
        m_busy = 1; m_went = 0; m_tgt = sel; m_go[sel] = 1;
`ifdef DM_HART_TIMEOUT_EN
        m_age = 0;
`endif
      end else e_err = 1;
    end else if (!was_busy && rr && sel < NH && m_halted[sel]) begin
      m_res[sel] = 1; m_ack[sel] = 0;
    end
  endfunction

  // One clock: drive inputs, let the edge happen, update model, release pulses at edge+1.
  task automatic cyc(input bit req, input bit we, input logic [11:0] a, input logic [31:0] wd,
                     input bit st, input bit rr, input int sel);
    mem_req = req; mem_we = we; mem_addr = a; mem_wdata = wd;
    cmd_start = st; resumereq = rr; hartsel = 4'(sel);
    @(posedge clk);
    model_step(req, we, a, wd, st, rr, sel);
    #1;
    mem_req = 0; mem_we = 0; cmd_start = 0; resumereq = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 12'h0, 32'h0, 0, 0, int'(hartsel));
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({mem_rsp, mem_rdata, cmd_busy, cmd_done, cmd_exception, cmd_err_halt, halted, resumeack} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rsp=%b rdata=%h busy=%b halted=%b ack=%b expected all 0",
               mem_rsp, mem_rdata, cmd_busy, halted, resumeack);
    end
    rst = 0;
    model_reset();
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 0);
    n_tests++;
    if (mem_rsp !== 1'b1 || mem_rdata !== 32'h0 || halted !== 4'b0 || cmd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read: rsp=%b rdata=%h halted=%b busy=%b expected 1 0 0000 0",
               mem_rsp, mem_rdata, halted, cmd_busy);
    end
    idle();
    n_tests++;
    if (mem_rsp !== 1'b0) begin
      n_fail++; $display("FAIL rsp_single: rsp=%b expected 0", mem_rsp);
    end
  endtask

  task automatic test_halt();
    cyc(1, 1, 12'h100, 32'h2, 0, 0, 0);
    n_tests++;
    if (halted !== 4'b0100 || mem_rsp !== 1'b1 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_write: halted=%b rsp=%b rdata=%h expected 0100 1 0", halted, mem_rsp, mem_rdata);
    end
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 0);
    n_tests++;
    if (mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL halt_flags: rdata=%h expected 00000000", mem_rdata);
    end
  endtask

  task automatic test_cmd_done();
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    n_tests++;
    if (cmd_busy !== 1'b1) begin n_fail++; $display("FAIL done_busy: busy=%b expected 1", cmd_busy); end
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 2);
    n_tests++;
    if (mem_rdata !== 32'h0001_0000) begin
      n_fail++; $display("FAIL done_go_flag: rdata=%h expected 00010000", mem_rdata);
    end
    cyc(1, 1, 12'h104, 32'h2, 0, 0, 2);
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 2);
    n_tests++;
    if (mem_rdata !== 32'h0 || cmd_busy !== 1'b1) begin
      n_fail++; $display("FAIL done_going: rdata=%h busy=%b expected 00000000 1", mem_rdata, cmd_busy);
    end
    cyc(1, 1, 12'h100, 32'h2, 0, 0, 2);
    n_tests++;
    if (cmd_done !== 1'b1 || cmd_busy !== 1'b0 || cmd_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b exc=%b expected 1 0 0", cmd_done, cmd_busy, cmd_exception);
    end
    idle();
    n_tests++;
    if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL done_single: done=%b expected 0", cmd_done); end
  endtask

  task automatic test_cmd_exception();
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    cyc(1, 1, 12'h104, 32'h2, 0, 0, 2);
    cyc(1, 1, 12'h10C, 32'h2, 0, 0, 2);
    n_tests++;
    if (cmd_exception !== 1'b1 || cmd_done !== 1'b0 || cmd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_pulse: exc=%b done=%b busy=%b expected 1 0 0", cmd_exception, cmd_done, cmd_busy);
    end
  endtask

  task automatic test_err_resume();
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 1);
    n_tests++;
    if (cmd_err_halt !== 1'b1 || cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL err_halt: err=%b busy=%b expected 1 0", cmd_err_halt, cmd_busy);
    end
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 1);
    n_tests++;
    if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL err_flags: rdata=%h expected 00000000", mem_rdata); end
    cyc(1, 1, 12'h100, 32'h1, 0, 0, 1);
    cyc(0, 0, 12'h0, 32'h0, 0, 1, 1);
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 1);
    n_tests++;
    if (mem_rdata !== 32'h0000_0200) begin
      n_fail++; $display("FAIL resume_flag: rdata=%h expected 00000200", mem_rdata);
    end
    cyc(1, 1, 12'h108, 32'h1, 0, 0, 1);
    n_tests++;
    if (halted !== 4'b0100 || resumeack !== 4'b0010) begin
      n_fail++; $display("FAIL resuming: halted=%b ack=%b expected 0100 0010", halted, resumeack);
    end
  endtask

`ifdef DM_HART_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    k = 0;
    while (cmd_exception !== 1'b1 && k < 20) begin
      idle();
      k++;
    end
    n_tests++;
    if (k != TO || cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_delay: cycles=%0d busy=%b expected %0d 0", k, cmd_busy, TO);
    end
    cyc(1, 0, 12'h400, 32'h0, 0, 0, 2);
    n_tests++;
    if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_go: rdata=%h expected 00000000", mem_rdata); end
  endtask
`else
  task automatic test_no_timeout();
    bit seen_exc;
    seen_exc = 0;
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    repeat (40) begin
      idle();
      if (cmd_exception === 1'b1) seen_exc = 1;
    end
    n_tests++;
    if (cmd_busy !== 1'b1 || seen_exc) begin
      n_fail++; $display("FAIL no_timeout: busy=%b exc_seen=%b expected 1 0", cmd_busy, seen_exc);
    end
    cyc(1, 1, 12'h104, 32'h2, 0, 0, 2);
    cyc(1, 1, 12'h100, 32'h2, 0, 0, 2);
    n_tests++;
    if (cmd_done !== 1'b1) begin n_fail++; $display("FAIL no_timeout_done: done=%b expected 1", cmd_done); end
  endtask
`endif

  task automatic test_reset_midcmd();
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    idle();
    rst = 1;
    #1;
    n_tests++;
    if ({cmd_busy, cmd_done, cmd_exception, cmd_err_halt, halted, resumeack} !== '0) begin
      n_fail++;
      $display("FAIL midcmd_reset: busy=%b done=%b exc=%b halted=%b expected 0 0 0 0000",
               cmd_busy, cmd_done, cmd_exception, halted);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    cyc(0, 0, 12'h0, 32'h0, 1, 0, 2);
    n_tests++;
    if (cmd_err_halt !== 1'b1 || cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL midcmd_after: err=%b busy=%b expected 1 0", cmd_err_halt, cmd_busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      int op, sel, wh;
      bit req, we, st, rr;
      logic [11:0] a;
      logic [31:0] wd;
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, NH - 1);
      wh  = (m_busy && $urandom_range(0, 1) == 1) ? m_tgt : $urandom_range(0, NH + 1);
      req = 0; we = 0; st = 0; rr = 0; a = '0;
      wd  = ($urandom() & 32'hFFFF_FFF0) | 32'(wh);
      case (op)
        0, 1:    begin req = 1; a = 12'h3FC + 12'($urandom_range(0, 10)); end
        2, 3, 4: begin req = 1; we = 1; a = 12'h100 + 12'(4 * $urandom_range(0, 4)); end
        5:       st = 1;
        6:       rr = 1;
        7:       begin req = 1; we = 1; rr = 1; a = 12'h100 + 12'(4 * $urandom_range(0, 3)); end
        default: ;
      endcase
      cyc(req, we, a, wd, st, rr, sel);
      n_tests++;
      if (mem_rsp !== e_rsp || mem_rdata !== e_rdata) begin
        n_fail++;
        $display("FAIL rand_mem[%0d]: rsp=%b rdata=%h expected %b %h", c, mem_rsp, mem_rdata, e_rsp, e_rdata);
      end
      n_tests++;
      if ({cmd_busy, cmd_done, cmd_exception, cmd_err_halt} !== {m_busy, e_done, e_exc, e_err}) begin
        n_fail++;
        $display("FAIL rand_cmd[%0d]: busy/done/exc/err=%b expected %b", c,
                 {cmd_busy, cmd_done, cmd_exception, cmd_err_halt}, {m_busy, e_done, e_exc, e_err});
      end
      n_tests++;
      if (halted !== m_halted || resumeack !== m_ack) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: halted=%b ack=%b expected %b %b", c, halted, resumeack, m_halted, m_ack);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_halt();
    test_cmd_done();
    test_cmd_exception();
    test_err_resume();
`ifdef DM_HART_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_midcmd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_hart_handshake.md
Name: dm_hart_handshake

Overview:
- Debug-memory responder for the debug module: the hart-side counterpart of the debug ROM park loop.
- Decodes hart stores to HALTED (0x100), GOING (0x104), RESUMING (0x108) and EXCEPTION (0x10C).
- Serves per-hart flag bytes at 0x400+hartid.
- Sequences abstract-command go and resume requests between the DM register file and parked harts; sits behind the DM memory slave port beside the ROM.

Parameters:
- AXI_DATA_W, 32, memory data width; only 32 or 64 legal, any other value is an elaboration error.
- NHART, 4, number of harts served, 1..16; hartid field is 4 bits.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with DM_HART_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_req  in  1  memory access valid, single cycle
- mem_we  in  1  1=write, 0=read
- mem_addr  in  12  byte address within debug memory
- mem_wdata  in  AXI_DATA_W  write data; hartid in bits [3:0] of the addressed word
- mem_rsp  out  1  response valid
- mem_rdata  out  AXI_DATA_W  read data
- hartsel  in  4  hart selected by the DM
- resumereq  in  1  pulse: resume the selected hart
- cmd_start  in  1  pulse: run the abstract program (jump to 0x300) on the selected hart
- cmd_busy  out  1  abstract command in flight
- cmd_done  out  1  pulse: command finished cleanly
- cmd_exception  out  1  pulse: command raised an exception or timed out
- cmd_err_halt  out  1  pulse: cmd_start rejected because the hart is not halted
- halted  out  NHART  per-hart halted status
- resumeack  out  NHART  per-hart sticky resume acknowledge

Behaviour:
- Reset: all outputs 0, all flags 0, FSM in IDLE, watchdog counter 0. Reset mid-command aborts without any pulse.
- Memory latency:
  - mem_rsp asserts exactly 1 cycle after mem_req, with mem_rdata registered.
  - Writes also respond, with mem_rdata=0.
  - Reads outside 0x400..0x400+NHART-1 return 0.
- Flag byte for hart h: bit0=go, bit1=resume, other bits 0.
- Flag read: mem_rdata byte lane i = flag byte of hart (aligned addr - 0x400 + i). Lanes for harts >= NHART read 0.
- Write decode (h = wdata[3:0] of the addressed word; ignored if h >= NHART; other addresses ignored):
  - HALTED: halted[h]=1; clears resume[h].
  - GOING: clears go[h].
  - RESUMING: halted[h]=0, resumeack[h]=1, clears resume[h].
  - EXCEPTION: recorded for the FSM only.
- Resume request:
  - resumereq with halted[hartsel]=1 and FSM IDLE: resume[hartsel]=1, resumeack[hartsel]=0.
  - Otherwise the request is ignored.
- Command FSM:
  - IDLE:
    - cmd_start and halted[hartsel]=0: pulse cmd_err_halt, stay IDLE.
    - cmd_start otherwise: latch hartsel as target, go[target]=1, go to GO; cmd_busy=1.
  - GO: GOING write from the target goes to EXEC. Writes from other harts are decoded normally but do not advance the FSM.
  - EXEC:
    - EXCEPTION write from the target: pulse cmd_exception, go to IDLE.
    - HALTED write from the target: pulse cmd_done, go to IDLE.
    - If both arrive, the first to arrive wins; only one write per cycle is possible.
  - cmd_busy=1 in GO and EXEC; it deasserts in the same cycle the done or exception pulse is emitted.
  - cmd_start while busy is ignored.
- Simultaneous events:
  - resumereq and a HALTED write for the same hart in one cycle: HALTED update applies, then resume is set.
  - cmd_start and resumereq in one cycle: cmd_start wins, resumereq is dropped.

Optional Feature:
- DM_HART_TIMEOUT_EN defined:
  - A 16-bit counter runs in GO and EXEC and clears on entry to GO.
  - When it reaches TIMEOUT_CYCLES: clear go[target], pulse cmd_exception, return to IDLE.
- Not defined: no counter; the FSM waits indefinitely.

Test Plan:
- Reset, then read 0x400 -> mem_rdata=0 one cycle later; halted=0, cmd_busy=0.
- Write 0x100 wdata=2 -> halted=4'b0100; read 0x400 (32-bit) -> 0x00000000.
- Hart 2 halted; hartsel=2, cmd_start -> read 0x400 gives 0x00010000 and cmd_busy=1. Then write 0x104 wdata=2 -> go cleared; then write 0x100 wdata=2 -> cmd_done pulse, cmd_busy=0.
- Same as above but write 0x10C wdata=2 in EXEC -> cmd_exception pulse, no cmd_done.
- hartsel=1 (not halted), cmd_start -> cmd_err_halt pulse, read 0x400 = 0. Then halt hart 1, resumereq -> byte1 = 0x02; write 0x108 wdata=1 -> halted[1]=0, resumeack[1]=1.
- With DM_HART_TIMEOUT_EN and TIMEOUT_CYCLES=8: cmd_start on a halted hart with no GOING write -> cmd_exception 8 cycles later, go flag reads 0.
